// File: rtl/alu_pkg.sv
// ALU opcode map, opcode legality check and ALU latency shared by the
// arbiter, its sub-blocks and the bench.
package alu_pkg;

  typedef enum logic [4:0] {
    OP_NOP  = 5'h00, OP_ADD  = 5'h01, OP_ADC  = 5'h02, OP_SUB  = 5'h03,
    OP_SBC  = 5'h04, OP_AND  = 5'h05, OP_OR   = 5'h06, OP_XOR  = 5'h07,
    OP_NOT  = 5'h08, OP_SHL  = 5'h09, OP_SHR  = 5'h0A, OP_ROL  = 5'h0B,
    OP_ROR  = 5'h0C, OP_INC  = 5'h0D, OP_DEC  = 5'h0E, OP_SWAP = 5'h0F,
    OP_MOV  = 5'h1E
  } alu_op_e;

  localparam int ALU_LATENCY = 1;

  // Legal opcodes are the low half of the map plus MOV; everything else in
  // 10000..11111 is reported as an error but still executed.
  function automatic logic op_legal(input logic [4:0] op);
    return (op[4] == 1'b0) || (op == OP_MOV);
  endfunction

endpackage

// File: rtl/alu_arb_if.sv
// Bundle of request, response and ALU-side signals for alu_arb.
// Lock inputs exist only when ALU_ARB_LOCK_EN is defined.
interface alu_arb_if #(parameter int DW = 8);

  logic          req0_valid, req0_ready;
  logic [4:0]    req0_op;
  logic [DW-1:0] req0_rd, req0_ra;
  logic          req1_valid, req1_ready;
  logic [4:0]    req1_op;
  logic [DW-1:0] req1_rd, req1_ra;
`ifdef ALU_ARB_LOCK_EN
  logic          req0_lock, req1_lock;
`endif

  logic          rsp0_valid, rsp0_cy, rsp0_zy, rsp0_err;
  logic [DW-1:0] rsp0_data;
  logic          rsp1_valid, rsp1_cy, rsp1_zy, rsp1_err;
  logic [DW-1:0] rsp1_data;

  logic          en_alu;
  logic [4:0]    aluop;
  logic [DW-1:0] RD, RA;
  logic [DW-1:0] alu_out;
  logic          alu_cy, alu_zy;

  modport slave (
`ifdef ALU_ARB_LOCK_EN
    input  req0_lock, req1_lock,
`endif
    input  req0_valid, req0_op, req0_rd, req0_ra,
    input  req1_valid, req1_op, req1_rd, req1_ra,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_data, rsp0_cy, rsp0_zy, rsp0_err,
    output rsp1_valid, rsp1_data, rsp1_cy, rsp1_zy, rsp1_err,
    output en_alu, aluop, RD, RA,
    input  alu_out, alu_cy, alu_zy
  );

  modport master (
`ifdef ALU_ARB_LOCK_EN
    output req0_lock, req1_lock,
`endif
    output req0_valid, req0_op, req0_rd, req0_ra,
    output req1_valid, req1_op, req1_rd, req1_ra,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_data, rsp0_cy, rsp0_zy, rsp0_err,
    input  rsp1_valid, rsp1_data, rsp1_cy, rsp1_zy, rsp1_err,
    input  en_alu, aluop, RD, RA,
    output alu_out, alu_cy, alu_zy
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; a one-hot hold input pins the grant on a
// requester for as long as it stays valid.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid,
  input  logic [1:0] hold,
  output logic [1:0] grant
);

  logic last_q;

  // Grant is only ever given to a valid requester, so grant == handshake.
  always_comb begin
    grant = 2'b00;
    if (reset)
      grant = 2'b00;
    else if (hold[0] && valid[0])
      grant = 2'b01;
    else if (hold[1] && valid[1])
      grant = 2'b10;
    else if (valid == 2'b11)
      grant = last_q ? 2'b01 : 2'b10;
    else
      grant = valid;
  end

  // last_q records which requester the last handshake served; it resets to 1
  // so requester 0 wins the first contested cycle.
  always_ff @(posedge clk) begin
    if (reset)
      last_q <= 1'b1;
    else if (grant[0])
      last_q <= 1'b0;
    else if (grant[1])
      last_q <= 1'b1;
  end

endmodule

// File: rtl/alu_arb.sv
// Two-requester front end for a single-cycle ALU: round-robin grant, issue
// register, response return. Define ALU_ARB_LOCK_EN for carry-chain locking.
module alu_arb
  import alu_pkg::*;
#(
  parameter int DW = 8
) (
  input logic      clk,
  input logic      reset,
  alu_arb_if.slave bus
);

  logic [1:0]    valid, hold, grant;
  logic [4:0]    op_in;
  logic [DW-1:0] rd_in, ra_in;

  logic          s1_valid, s1_id;
  logic [4:0]    s1_op;
  logic [DW-1:0] s1_rd, s1_ra;
  logic          s2_valid, s2_id, s2_err;
  logic          rsp0_hit, rsp1_hit;

  assign valid = {bus.req1_valid, bus.req0_valid};

`ifdef ALU_ARB_LOCK_EN
  logic [1:0] lock_q;

  // A handshake sets or clears its own lock; a locked requester that drops
  // valid for a cycle loses the lock.
  always_ff @(posedge clk) begin
    if (reset)
      lock_q <= 2'b00;
    else if (grant[0])
      lock_q <= {1'b0, bus.req0_lock};
    else if (grant[1])
      lock_q <= {bus.req1_lock, 1'b0};
    else
      lock_q <= lock_q & valid;
  end

  assign hold = lock_q;
`else
  assign hold = 2'b00;
`endif

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .valid (valid),
    .hold  (hold),
    .grant (grant)
  );

  assign bus.req0_ready = grant[0];
  assign bus.req1_ready = grant[1];

  always_comb begin
    op_in = bus.req0_op;
    rd_in = bus.req0_rd;
    ra_in = bus.req0_ra;
    if (grant[1]) begin
      op_in = bus.req1_op;
      rd_in = bus.req1_rd;
      ra_in = bus.req1_ra;
    end
  end

  // Stage 1 holds the op presented to the ALU; stage 2 tracks whose result
  // the ALU is returning this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_id    <= 1'b0;
      s1_op    <= '0;
      s1_rd    <= '0;
      s1_ra    <= '0;
      s2_valid <= 1'b0;
      s2_id    <= 1'b0;
      s2_err   <= 1'b0;
    end else begin
      s1_valid <= |grant;
      s1_id    <= grant[1];
      s1_op    <= (|grant) ? op_in : '0;
      s1_rd    <= (|grant) ? rd_in : '0;
      s1_ra    <= (|grant) ? ra_in : '0;
      s2_valid <= s1_valid;
      s2_id    <= s1_id;
      s2_err   <= s1_valid && !op_legal(s1_op);
    end
  end

  assign bus.en_alu = s1_valid && !reset;
  assign bus.aluop  = reset ? '0 : s1_op;
  assign bus.RD     = reset ? '0 : s1_rd;
  assign bus.RA     = reset ? '0 : s1_ra;

  assign rsp0_hit = s2_valid && !s2_id && !reset;
  assign rsp1_hit = s2_valid &&  s2_id && !reset;

  assign bus.rsp0_valid = rsp0_hit;
  assign bus.rsp0_data  = rsp0_hit ? bus.alu_out : '0;
  assign bus.rsp0_cy    = rsp0_hit && bus.alu_cy;
  assign bus.rsp0_zy    = rsp0_hit && bus.alu_zy;
  assign bus.rsp0_err   = rsp0_hit && s2_err;

  assign bus.rsp1_valid = rsp1_hit;
  assign bus.rsp1_data  = rsp1_hit ? bus.alu_out : '0;
  assign bus.rsp1_cy    = rsp1_hit && bus.alu_cy;
  assign bus.rsp1_zy    = rsp1_hit && bus.alu_zy;
  assign bus.rsp1_err   = rsp1_hit && s2_err;

endmodule

// File: tb/tb_alu_arb.sv
// Scoreboard bench for alu_arb: directed steps push expected issue/response
// entries, a negedge monitor pops and compares them against the DUT.
module tb_alu_arb;
  import alu_pkg::*;

  typedef struct {
    int         cyc;
    logic [4:0] op;
    logic [7:0] rd, ra;
  } iss_t;

  typedef struct {
    int         cyc;
    logic       id;
    logic [7:0] data;
    logic       cy, zy, err;
  } rsp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic mon_en = 1'b0;
  logic [8:0] alu_sum;

  iss_t iss_q[$];
  rsp_t rsp_q[$];

  alu_arb_if #(.DW(8)) bus ();

  alu_arb #(.DW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference ALU: one-cycle latency, carry flag persists for ADC.
  always @(posedge clk) begin
    if (reset) begin
      bus.alu_out <= 8'h00;
      bus.alu_cy  <= 1'b0;
      bus.alu_zy  <= 1'b0;
    end else if (bus.en_alu) begin
      alu_sum = 9'd0;
      case (bus.aluop)
        OP_ADD:  alu_sum = {1'b0, bus.RD} + {1'b0, bus.RA};
        OP_ADC:  alu_sum = {1'b0, bus.RD} + {1'b0, bus.RA} + {8'd0, bus.alu_cy};
        OP_AND:  alu_sum = {1'b0, bus.RD & bus.RA};
        OP_XOR:  alu_sum = {1'b0, bus.RD ^ bus.RA};
        OP_MOV:  alu_sum = {1'b0, bus.RA};
        OP_SWAP: alu_sum = {1'b0, bus.RD[3:0], bus.RD[7:4]};
        default: alu_sum = 9'd0;
      endcase
      bus.alu_out <= alu_sum[7:0];
      bus.alu_cy  <= alu_sum[8];
      bus.alu_zy  <= (alu_sum[7:0] == 8'h00);
    end
  end

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_rsp(input logic id, input logic [7:0] data,
                           input logic cy, input logic zy, input logic err);
    rsp_t e;
    if (rsp_q.size() == 0) begin
      check_output("rsp_unexpected", {31'd0, id}, 32'hFFFF_FFFF);
    end else begin
      e = rsp_q.pop_front();
      check_output("rsp_id", {31'd0, id}, {31'd0, e.id});
      check_output("rsp_cycle", cyc, e.cyc + 2);
      check_output("rsp_data", {24'd0, data}, {24'd0, e.data});
      check_output("rsp_flags", {29'd0, cy, zy, err}, {29'd0, e.cy, e.zy, e.err});
    end
  endtask

  // Monitor: pops expectations whenever the DUT issues or responds.
  always @(negedge clk) begin
    if (mon_en) begin
      check_output("grant_onehot", {30'd0, bus.req1_ready, bus.req0_ready} == 2'b11,
                   32'd0);
      if (bus.en_alu) begin
        if (iss_q.size() == 0) begin
          check_output("issue_unexpected", {27'd0, bus.aluop}, 32'hFFFF_FFFF);
        end else begin
          iss_t e;
          e = iss_q.pop_front();
          check_output("issue_cycle", cyc, e.cyc + 1);
          check_output("issue_bus", {3'd0, bus.aluop, bus.RD, bus.RA, 8'd0},
                       {3'd0, e.op, e.rd, e.ra, 8'd0});
        end
      end else begin
        check_output("idle_alu_bus", {3'd0, bus.aluop, bus.RD, bus.RA, 8'd0}, 32'd0);
      end
      if (bus.rsp0_valid)
        check_rsp(1'b0, bus.rsp0_data, bus.rsp0_cy, bus.rsp0_zy, bus.rsp0_err);
      else
        check_output("idle_rsp0", {21'd0, bus.rsp0_data, bus.rsp0_cy, bus.rsp0_zy,
                     bus.rsp0_err}, 32'd0);
      if (bus.rsp1_valid)
        check_rsp(1'b1, bus.rsp1_data, bus.rsp1_cy, bus.rsp1_zy, bus.rsp1_err);
      else
        check_output("idle_rsp1", {21'd0, bus.rsp1_data, bus.rsp1_cy, bus.rsp1_zy,
                     bus.rsp1_err}, 32'd0);
    end
  end

  // One cycle of stimulus: drive, check the grant mid-cycle and, for an
  // expected handshake, queue the hand-computed issue and response.
  task automatic apply_stimulus(
    input logic v0, input logic [4:0] op0, input logic [7:0] rd0, ra0, input logic lk0,
    input logic v1, input logic [4:0] op1, input logic [7:0] rd1, ra1, input logic lk1,
    input logic [1:0] grant, input logic [7:0] data, input logic cy, zy, err,
    input logic drop);
    iss_t i;
    rsp_t r;
    @(posedge clk);
    #1;
    bus.req0_valid = v0; bus.req0_op = op0; bus.req0_rd = rd0; bus.req0_ra = ra0;
    bus.req1_valid = v1; bus.req1_op = op1; bus.req1_rd = rd1; bus.req1_ra = ra1;
`ifdef ALU_ARB_LOCK_EN
    bus.req0_lock = lk0;
    bus.req1_lock = lk1;
`else
    if (lk0 || lk1) $display("[TB] lock request ignored in this build");
`endif
    @(negedge clk);
    check_output("grant", {30'd0, bus.req1_ready, bus.req0_ready}, {30'd0, grant});
    if (grant != 2'b00 && !drop) begin
      i.cyc = cyc;
      i.op  = grant[1] ? op1 : op0;
      i.rd  = grant[1] ? rd1 : rd0;
      i.ra  = grant[1] ? ra1 : ra0;
      iss_q.push_back(i);
      r.cyc = cyc; r.id = grant[1]; r.data = data; r.cy = cy; r.zy = zy; r.err = err;
      rsp_q.push_back(r);
    end
  endtask

  task automatic idle_step();
    apply_stimulus(0, OP_NOP, 8'h00, 8'h00, 0, 0, OP_NOP, 8'h00, 8'h00, 0,
                   2'b00, 8'h00, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    bus.req0_valid = 1'b1; bus.req0_op = OP_ADD; bus.req0_rd = 8'h11; bus.req0_ra = 8'h22;
    bus.req1_valid = 1'b1; bus.req1_op = OP_ADD; bus.req1_rd = 8'h33; bus.req1_ra = 8'h44;
`ifdef ALU_ARB_LOCK_EN
    bus.req0_lock = 1'b0;
    bus.req1_lock = 1'b0;
`endif
    @(posedge clk);
    mon_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("reset_ready", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
    check_output("reset_en_alu", {31'd0, bus.en_alu}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;

    // Both requesters contend: grants alternate starting with 0.
    apply_stimulus(1, OP_ADD, 8'h01, 8'h02, 0, 1, OP_XOR, 8'hAA, 8'h55, 0,
                   2'b01, 8'h03, 0, 0, 0, 0);
    apply_stimulus(1, OP_AND, 8'hF0, 8'h0F, 0, 1, OP_XOR, 8'hAA, 8'h55, 0,
                   2'b10, 8'hFF, 0, 0, 0, 0);
    apply_stimulus(1, OP_AND, 8'hF0, 8'h0F, 0, 1, OP_ADD, 8'h80, 8'h80, 0,
                   2'b01, 8'h00, 0, 1, 0, 0);
    apply_stimulus(1, OP_ADD, 8'h0F, 8'h01, 0, 1, OP_ADD, 8'h80, 8'h80, 0,
                   2'b10, 8'h00, 1, 1, 0, 0);

    // Single requester, then opcode-legality boundaries back to back.
    apply_stimulus(1, OP_ADD, 8'h0F, 8'h01, 0, 0, OP_NOP, 8'h00, 8'h00, 0,
                   2'b01, 8'h10, 0, 0, 0, 0);
    apply_stimulus(0, OP_NOP, 8'h00, 8'h00, 0, 1, 5'b10101, 8'h00, 8'h00, 0,
                   2'b10, 8'h00, 0, 1, 1, 0);
    apply_stimulus(1, OP_MOV, 8'h00, 8'h5A, 0, 0, OP_NOP, 8'h00, 8'h00, 0,
                   2'b01, 8'h5A, 0, 0, 0, 0);
    apply_stimulus(1, 5'b11111, 8'h00, 8'h00, 0, 0, OP_NOP, 8'h00, 8'h00, 0,
                   2'b01, 8'h00, 0, 1, 1, 0);
    apply_stimulus(1, OP_SWAP, 8'h12, 8'h00, 0, 0, OP_NOP, 8'h00, 8'h00, 0,
                   2'b01, 8'h21, 0, 0, 0, 0);
    apply_stimulus(1, 5'b10000, 8'h00, 8'h00, 0, 0, OP_NOP, 8'h00, 8'h00, 0,
                   2'b01, 8'h00, 0, 1, 1, 0);
    idle_step();
    idle_step();

    // Reset lands in the issue cycle of an accepted op: it must vanish.
    apply_stimulus(1, OP_ADD, 8'h01, 8'h01, 0, 0, OP_NOP, 8'h00, 8'h00, 0,
                   2'b01, 8'h00, 0, 0, 0, 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus.req0_valid = 1'b0;
    @(negedge clk);
    check_output("reset_a1_en_alu", {31'd0, bus.en_alu}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    apply_stimulus(1, OP_ADD, 8'h02, 8'h03, 0, 1, OP_XOR, 8'h0F, 8'h0F, 0,
                   2'b01, 8'h05, 0, 0, 0, 0);
    apply_stimulus(1, OP_ADD, 8'h02, 8'h03, 0, 1, OP_XOR, 8'h0F, 8'h0F, 0,
                   2'b10, 8'h00, 0, 1, 0, 0);

`ifdef ALU_ARB_LOCK_EN
    // Locked ADD/ADC carry chain keeps requester 1 waiting.
    apply_stimulus(1, OP_ADD, 8'hFF, 8'h01, 1, 1, OP_XOR, 8'h33, 8'h33, 0,
                   2'b01, 8'h00, 1, 1, 0, 0);
    apply_stimulus(1, OP_ADC, 8'h00, 8'h00, 0, 1, OP_XOR, 8'h33, 8'h33, 0,
                   2'b01, 8'h01, 0, 0, 0, 0);
    apply_stimulus(0, OP_NOP, 8'h00, 8'h00, 0, 1, OP_XOR, 8'h33, 8'h33, 0,
                   2'b10, 8'h00, 0, 1, 0, 0);
`endif

    repeat (4) idle_step();
    check_output("iss_drained", iss_q.size(), 32'd0);
    check_output("rsp_drained", rsp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arb.md
ALU_ARB -- requirements
Module: alu_arb

Interface
REQ-001 SHALL have parameter DW, default 8, meaning operand/result width (matches the ALU datapath).
REQ-002 SHALL have port clk  in  1  single clock, all logic on posedge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports reqN_valid  in  1 / reqN_ready  out  1  valid/ready request handshake, N=0,1.
REQ-005 SHALL have ports reqN_op  in  5 / reqN_rd  in  DW / reqN_ra  in  DW  opcode and operands, N=0,1.
REQ-006 SHALL have port reqN_lock  in  1  hold the grant for the next op (carry chain), N=0,1; present only with ALU_ARB_LOCK_EN.
REQ-007 SHALL have ports rspN_valid  out  1 / rspN_data  out  DW / rspN_cy  out  1 / rspN_zy  out  1 / rspN_err  out  1  result return, N=0,1.
REQ-008 SHALL have ports en_alu  out  1 / aluop  out  5 / RD  out  DW / RA  out  DW  to the ALU.
REQ-009 SHALL have ports alu_out  in  DW / alu_cy  in  1 / alu_zy  in  1  from the ALU.

Function
REQ-010 SHALL assert at most one reqN_ready per cycle; reqN_ready is the grant and may depend combinationally on reqN_valid.
REQ-011 SHALL arbitrate round-robin: with both valid, grant the requester not served by the last accepted handshake; with one valid, grant it.
REQ-012 SHALL register the accepted op so that in cycle A+1 (A = handshake cycle) en_alu=1 and aluop/RD/RA equal the accepted op/rd/ra.
REQ-013 SHALL drive en_alu=0 and aluop/RD/RA=0 in any cycle with no op issued.
REQ-014 SHALL assert rspN_valid for exactly one cycle, in cycle A+2, only for the requester whose op was accepted in cycle A; rspN_data/cy/zy = alu_out/alu_cy/alu_zy in that cycle.
REQ-015 SHALL sustain one accepted op per cycle (2-stage pipeline, no bubbles); responses have no backpressure.
REQ-016 SHALL drive rspN_data/cy/zy/err to 0 when rspN_valid=0.
REQ-017 SHALL flag rspN_err=1 for opcodes 5'b10000-5'b11101 and 5'b11111; the op is still issued and the ALU result returned unchanged.
REQ-018 SHALL not reorder: responses return in acceptance order.

Reset
REQ-019 SHALL, while reset=1, drive all ready, rsp*, en_alu, aluop, RD, RA to 0 and discard in-flight ops (no response for them).
REQ-020 SHALL, on the first cycle after reset, give requester 0 priority and clear any lock.

Configuration
REQ-021 SHALL, with ALU_ARB_LOCK_EN defined, keep the grant on requester N after it accepts an op with reqN_lock=1, until it accepts an op with reqN_lock=0 or its reqN_valid is 0 for one cycle (lock released, round-robin resumes).
REQ-022 SHALL, with ALU_ARB_LOCK_EN defined, guarantee back-to-back issue with en_alu held 1 while a locked requester presents valid every cycle (ADC chain keeps ALU carry).
REQ-023 SHALL, without ALU_ARB_LOCK_EN, omit reqN_lock ports and lock state; pure round-robin.

Structure
REQ-024 SHALL place ALU opcode constants (NOP..SWAP, MOV=5'b11110), the opcode-legal function and the ALU latency constant (1) in package alu_pkg.
REQ-025 SHALL implement the grant in one sub-module rr_arb2 (2-way round-robin with lock-hold input); pipeline/response logic stays in alu_arb.

Verification
REQ-026 SHALL cover: req0 ADD rd=8'h0F ra=8'h01 alone -> en_alu=1 at A+1, rsp0_valid at A+2, data=8'h10, cy=0, zy=0.
REQ-027 SHALL cover: both valid every cycle, 4 cycles -> grants 0,1,0,1; responses alternate 0,1,0,1 at A+2.
REQ-028 SHALL cover (LOCK_EN): req0 ADD 8'hFF+8'h01 lock=1 then ADC 8'h00+8'h00 lock=0, req1 valid throughout -> req1 not granted until after the ADC; ADC result data=8'h01.
REQ-029 SHALL cover: req1 op=5'b10101 -> rsp1_valid, rsp1_err=1, data=8'h00.
REQ-030 SHALL cover: reset asserted in cycle A+1 of an accepted op -> no rsp*_valid afterwards, en_alu=0, next grant with both valid goes to requester 0.
